// File: rtl/therm_adc_reader.sv
// rtl/therm_adc_reader.sv - periodic serial-ADC thermistor sampler with 2^AVG_LOG2 averaging
module therm_adc_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int AVG_LOG2      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       adc_do,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [7:0] v_therm,
  output logic       v_valid,
  output logic       busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PER_W = $clog2(SAMPLE_PERIOD);
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, WAIT, SETUP, NULLBIT, SHIFT, DONE} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_n;
  logic               sclk_hi, hi_n;
  logic [2:0]         bit_cnt, bit_n;
  logic               capture;
  logic [PER_W-1:0]   per_cnt;
  logic               do_s1, do_s2;
  logic [7:0]         shreg;
  logic [ACC_W-1:0]   acc, sum;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         avg, res;
  logic               fire;
  logic               half_end, conv_n, sclk_n;

  assign half_end = (div_cnt == DIV_LAST);
  assign sum      = acc + ACC_W'(shreg);
  assign avg      = 8'(sum >> AVG_LOG2);
  assign busy     = ~adc_cs_n;

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    hi_n    = sclk_hi;
    bit_n   = bit_cnt;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n = SETUP;
          div_n   = '0;
          hi_n    = 1'b0;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (per_cnt == PER_LAST) begin
          state_n = SETUP;
          div_n   = '0;
          hi_n    = 1'b0;
        end
      end
      SETUP: begin
        div_n = div_cnt + DIV_W'(1);
        if (half_end) begin
          state_n = NULLBIT;
          div_n   = '0;
          hi_n    = 1'b0;
        end
      end
      NULLBIT, SHIFT: begin
        div_n = div_cnt + DIV_W'(1);
        if (half_end) begin
          div_n = '0;
          hi_n  = ~sclk_hi;
          // End of a high phase closes one SCLK period
          if (sclk_hi) begin
            if (state == NULLBIT) begin
              state_n = SHIFT;
              bit_n   = 3'd7;
            end else begin
              capture = 1'b1;
              if (bit_cnt == 3'd0) state_n = DONE;
              else                 bit_n   = bit_cnt - 3'd1;
            end
          end
        end
      end
      DONE:    state_n = enable ? WAIT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign conv_n = (state_n == SETUP) || (state_n == NULLBIT) || (state_n == SHIFT);
  assign sclk_n = ((state_n == NULLBIT) || (state_n == SHIFT)) && hi_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      sclk_hi  <= 1'b0;
      bit_cnt  <= '0;
      per_cnt  <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      do_s1    <= 1'b0;
      do_s2    <= 1'b0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      sclk_hi  <= hi_n;
      bit_cnt  <= bit_n;
      adc_cs_n <= ~conv_n;
      adc_sclk <= sclk_n;
      do_s1    <= adc_do;
      do_s2    <= do_s1;
      if (capture) shreg <= {shreg[6:0], do_s2};
      // Period is measured start-to-start from each SETUP entry
      if ((state_n == SETUP && state != SETUP) || state == IDLE) per_cnt <= '0;
      else                                                        per_cnt <= per_cnt + PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      res     <= '0;
      fire    <= 1'b0;
      v_therm <= '0;
      v_valid <= 1'b0;
    end else begin
      fire    <= 1'b0;
      v_valid <= fire;
      if (fire) v_therm <= res;
      if (state == DONE && cnt == CNT_LAST) begin
        res  <= avg;
        fire <= 1'b1;
        acc  <= '0;
        cnt  <= '0;
      end else if (state_n == IDLE) begin
        acc <= '0;
        cnt <= '0;
      end else if (state == DONE) begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
